// File: rtl/yarp_pkg.sv
// Shared types for the yarp core: access-size encoding and memory arbiter state/owner enums.
package yarp_pkg;

  typedef enum logic [1:0] {
    BYTE      = 2'b00,
    HALF_WORD = 2'b01,
    WORD      = 2'b10
  } mem_access_size_e;

  localparam int unsigned MEM_BE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RSP,
    ERR_RSP
  } mem_arb_state_e;

  typedef enum logic {
    OWN_INSTR,
    OWN_DATA
  } mem_owner_e;

endpackage

// File: rtl/yarp_mem_be_gen.sv
// Byte-enable / write-lane generator for load/store accesses; also flags misalignment.
module yarp_mem_be_gen
  import yarp_pkg::*;
(
  input  logic [1:0]          addr_lo_i,
  input  logic [1:0]          data_byte_i,
  input  logic [31:0]         wdata_i,
  output logic [MEM_BE_W-1:0] be_o,
  output logic [31:0]         wdata_o,
  output logic                misaligned_o
);

  always_comb begin
    be_o         = '0;
    wdata_o      = wdata_i;
    misaligned_o = 1'b0;
    case (mem_access_size_e'(data_byte_i))
      BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      HALF_WORD: begin
        be_o         = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o      = {2{wdata_i[15:0]}};
        misaligned_o = addr_lo_i[0];
      end
      WORD: begin
        be_o         = 4'hF;
        misaligned_o = |addr_lo_i;
      end
      // Unused size code: reject as misaligned so no memory access is made.
      default: misaligned_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/yarp_mem_arbiter.sv
// Arbitrates the single OBI-style memory port between instruction fetch and load/store.
// One outstanding transaction; data has priority with a starvation guard for fetch.
module yarp_mem_arbiter
  import yarp_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_req_i,
  input  logic [31:0]         instr_addr_i,
  output logic                instr_gnt_o,
  output logic                instr_rvalid_o,
  output logic [31:0]         instr_rdata_o,
  output logic                instr_err_o,
  input  logic                data_req_i,
  input  logic [31:0]         data_addr_i,
  input  logic                data_wr_i,
  input  logic [1:0]          data_byte_i,
  input  logic [31:0]         data_wdata_i,
  output logic                data_gnt_o,
  output logic                data_rvalid_o,
  output logic [31:0]         data_rdata_o,
  output logic                data_err_o,
  output logic                mem_req_o,
  output logic [31:0]         mem_addr_o,
  output logic                mem_we_o,
  output logic [MEM_BE_W-1:0] mem_be_o,
  output logic [31:0]         mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [31:0]         mem_rdata_i
);

  localparam int unsigned       STARVE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [7:0]        TMO_MAX    = 8'(TIMEOUT_CYCLES);

  mem_arb_state_e      r_state, w_state_nxt;
  mem_owner_e          r_owner;
  logic [31:0]         r_addr;
  logic                r_we;
  logic [MEM_BE_W-1:0] r_be;
  logic [31:0]         r_wdata;
  logic [STARVE_W-1:0] r_starve, w_starve_nxt;
  logic [7:0]          r_tmo, w_tmo_nxt;

  logic [MEM_BE_W-1:0] w_be;
  logic [31:0]         w_wdata_rep;
  logic                w_misaligned;
  logic                w_fetch_win, w_data_win, w_latch;
  logic                w_gnt, w_err_gnt, w_rsp, w_rsp_err;
  logic [31:0]         w_rsp_data;
  logic                w_unused_instr_lo;

  assign w_unused_instr_lo = ^instr_addr_i[1:0];

  yarp_mem_be_gen u_be_gen (
    .addr_lo_i    (data_addr_i[1:0]),
    .data_byte_i  (data_byte_i),
    .wdata_i      (data_wdata_i),
    .be_o         (w_be),
    .wdata_o      (w_wdata_rep),
    .misaligned_o (w_misaligned)
  );

  assign w_fetch_win = instr_req_i && (!data_req_i || (r_starve == STARVE_MAX));
  assign w_data_win  = data_req_i && !w_fetch_win;

  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve;
    w_tmo_nxt    = r_tmo;
    w_latch      = 1'b0;
    w_gnt        = 1'b0;
    w_err_gnt    = 1'b0;
    w_rsp        = 1'b0;
    w_rsp_err    = 1'b0;
    w_rsp_data   = '0;
    mem_req_o    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_tmo_nxt = '0;
        if (w_fetch_win) begin
          w_starve_nxt = '0;
          w_latch      = 1'b1;
          w_state_nxt  = WAIT_GNT;
        end else if (w_data_win) begin
          if (instr_req_i) w_starve_nxt = r_starve + 1'b1;
          w_latch = 1'b1;
          if (w_misaligned) begin
            w_err_gnt   = 1'b1;
            w_state_nxt = ERR_RSP;
          end else begin
            w_state_nxt = WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) begin
          w_gnt     = 1'b1;
          w_tmo_nxt = '0;
          if (mem_rvalid_i) begin
            w_rsp       = 1'b1;
            w_rsp_data  = mem_rdata_i;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        if (mem_rvalid_i) begin
          w_rsp       = 1'b1;
          w_rsp_data  = mem_rdata_i;
          w_state_nxt = IDLE;
        end else if (r_tmo == TMO_MAX) begin
          w_rsp       = 1'b1;
          w_rsp_err   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_tmo_nxt = r_tmo + 8'd1;
        end
      end
      ERR_RSP: begin
        w_rsp       = 1'b1;
        w_rsp_err   = 1'b1;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign instr_gnt_o    = w_gnt && (r_owner == OWN_INSTR);
  assign data_gnt_o     = (w_gnt && (r_owner == OWN_DATA)) || w_err_gnt;
  assign instr_rvalid_o = w_rsp && (r_owner == OWN_INSTR);
  assign data_rvalid_o  = w_rsp && (r_owner == OWN_DATA);
  assign instr_err_o    = instr_rvalid_o && w_rsp_err;
  assign data_err_o     = data_rvalid_o && w_rsp_err;
  assign instr_rdata_o  = instr_rvalid_o ? w_rsp_data : '0;
  assign data_rdata_o   = data_rvalid_o ? w_rsp_data : '0;

  assign mem_addr_o  = r_addr;
  assign mem_we_o    = r_we;
  assign mem_be_o    = r_be;
  assign mem_wdata_o = r_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_owner  <= OWN_INSTR;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_be     <= '0;
      r_wdata  <= '0;
      r_starve <= '0;
      r_tmo    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
      r_tmo    <= w_tmo_nxt;
      if (w_latch) begin
        r_owner <= w_fetch_win ? OWN_INSTR : OWN_DATA;
        r_addr  <= w_fetch_win ? {instr_addr_i[31:2], 2'b00} : {data_addr_i[31:2], 2'b00};
        r_we    <= w_fetch_win ? 1'b0 : data_wr_i;
        r_be    <= w_fetch_win ? 4'hF : w_be;
        r_wdata <= w_fetch_win ? 32'h0 : w_wdata_rep;
      end
    end
  end

endmodule

// File: tb/tb_yarp_mem_arbiter.sv
// Directed self-checking bench for yarp_mem_arbiter.
module tb_yarp_mem_arbiter;
  import yarp_pkg::*;

  logic        clk, reset;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic        data_req_i, data_wr_i, data_gnt_o, data_rvalid_o, data_err_o;
  logic [1:0]  data_byte_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [9:0]  ord;
  int          ngr;
  int          n;
  logic        any_out;

  assign any_out = |{instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o, data_gnt_o,
                     data_rvalid_o, data_rdata_o, data_err_o, mem_req_o, mem_addr_o, mem_we_o,
                     mem_be_o, mem_wdata_o};

  yarp_mem_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .instr_err_o    (instr_err_o),
    .data_req_i     (data_req_i),
    .data_addr_i    (data_addr_i),
    .data_wr_i      (data_wr_i),
    .data_byte_i    (data_byte_i),
    .data_wdata_i   (data_wdata_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .data_err_o     (data_err_o),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1;
    instr_req_i = 0; instr_addr_i = '0;
    data_req_i = 0; data_addr_i = '0; data_wr_i = 0; data_byte_i = WORD; data_wdata_i = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    tick(); tick(); #1;
    chk("rst_all_zero", 32'(any_out), 0);
    reset = 1'b0;

    // 1: solo fetch, one wait cycle on gnt and on rvalid
    instr_req_i = 1; instr_addr_i = 32'h100; #1;
    chk("t1_idle_no_req", 32'(mem_req_o), 0);
    tick(); #1;
    chk("t1_req", 32'(mem_req_o), 1);
    chk("t1_addr", mem_addr_o, 32'h100);
    chk("t1_be", 32'(mem_be_o), 32'hF);
    chk("t1_we", 32'(mem_we_o), 0);
    chk("t1_no_gnt_yet", 32'(instr_gnt_o), 0);
    tick(); mem_gnt_i = 1; #1;
    chk("t1_gnt", 32'(instr_gnt_o), 1);
    chk("t1_data_gnt_0", 32'(data_gnt_o), 0);
    tick(); instr_req_i = 0; mem_gnt_i = 0; #1;
    chk("t1_req_drop", 32'(mem_req_o), 0);
    chk("t1_no_rvalid_yet", 32'(instr_rvalid_o), 0);
    tick(); mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF; #1;
    chk("t1_rvalid", 32'(instr_rvalid_o), 1);
    chk("t1_rdata", instr_rdata_o, 32'hDEADBEEF);
    chk("t1_err", 32'(instr_err_o), 0);
    chk("t1_data_rvalid_0", 32'(data_rvalid_o), 0);
    tick(); mem_rvalid_i = 0;

    // 2: store byte at 0x203
    data_req_i = 1; data_addr_i = 32'h203; data_wr_i = 1; data_byte_i = BYTE;
    data_wdata_i = 32'h0000_00A5;
    tick(); mem_gnt_i = 1; #1;
    chk("t2_addr", mem_addr_o, 32'h200);
    chk("t2_be", 32'(mem_be_o), 32'h8);
    chk("t2_wdata", mem_wdata_o, 32'hA5A5A5A5);
    chk("t2_we", 32'(mem_we_o), 1);
    chk("t2_gnt", 32'(data_gnt_o), 1);
    tick(); data_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h11223344; #1;
    chk("t2_rvalid", 32'(data_rvalid_o), 1);
    chk("t2_err", 32'(data_err_o), 0);
    chk("t2_rdata", data_rdata_o, 32'h11223344);
    chk("t2_instr_rvalid_0", 32'(instr_rvalid_o), 0);
    tick(); mem_rvalid_i = 0;

    // 2b: store half at 0x106, zero-wait memory
    data_req_i = 1; data_addr_i = 32'h106; data_byte_i = HALF_WORD; data_wdata_i = 32'hFFFF1234;
    tick(); mem_gnt_i = 1; mem_rvalid_i = 1; #1;
    chk("t2b_be", 32'(mem_be_o), 32'hC);
    chk("t2b_wdata", mem_wdata_o, 32'h12341234);
    chk("t2b_rvalid", 32'(data_rvalid_o), 1);
    tick(); data_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; data_wr_i = 0;

    // 3: misaligned word load
    data_req_i = 1; data_addr_i = 32'h102; data_byte_i = WORD; #1;
    chk("t3_gnt", 32'(data_gnt_o), 1);
    chk("t3_no_req_idle", 32'(mem_req_o), 0);
    tick(); data_req_i = 0; #1;
    chk("t3_rvalid", 32'(data_rvalid_o), 1);
    chk("t3_err", 32'(data_err_o), 1);
    chk("t3_no_req_err", 32'(mem_req_o), 0);
    chk("t3_gnt_drop", 32'(data_gnt_o), 0);
    tick(); #1;
    chk("t3_done", 32'({data_rvalid_o, mem_req_o}), 0);

    // 4: starvation guard, both requesters always asking, zero-wait memory
    instr_req_i = 1; instr_addr_i = 32'h800; data_req_i = 1; data_addr_i = 32'h900;
    mem_gnt_i = 1; mem_rvalid_i = 1;
    ord = '0; ngr = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (instr_gnt_o || data_gnt_o) begin
        ord = {ord[8:0], instr_gnt_o};
        ngr++;
      end
      tick();
    end
    instr_req_i = 0; data_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
    chk("t4_order", 32'(ord), 32'b0000100001);
    chk("t4_count", 32'(ngr), 10);

    // 5: load with no response times out
    #1; data_req_i = 1; data_addr_i = 32'h300; data_byte_i = WORD;
    tick(); mem_gnt_i = 1; #1;
    chk("t5_gnt", 32'(data_gnt_o), 1);
    tick(); data_req_i = 0; mem_gnt_i = 0; mem_rdata_i = 32'hCAFEF00D; #1;
    n = 0;
    while (!data_rvalid_o && n < 400) begin
      tick();
      n++;
    end
    chk("t5_tmo_cycles", 32'(n), 255);
    chk("t5_rvalid", 32'(data_rvalid_o), 1);
    chk("t5_err", 32'(data_err_o), 1);
    chk("t5_rdata_zero", data_rdata_o, 0);
    tick(); mem_rvalid_i = 1; #1;
    chk("t5_stray", 32'({data_rvalid_o, instr_rvalid_o, mem_req_o}), 0);
    tick(); mem_rvalid_i = 0; #1;
    chk("t5_stray_after", 32'({data_rvalid_o, instr_rvalid_o, mem_req_o}), 0);

    // 6: reset while waiting for a response
    data_req_i = 1; data_addr_i = 32'h400;
    tick(); mem_gnt_i = 1;
    tick(); data_req_i = 0; mem_gnt_i = 0; #1;
    chk("t6_in_rsp", 32'({data_rvalid_o, mem_req_o}), 0);
    reset = 1;
    tick(); reset = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h55AA55AA; #1;
    chk("t6_all_zero", 32'(any_out), 0);
    tick(); mem_rvalid_i = 0; #1;
    chk("t6_still_zero", 32'(any_out), 0);

    // 6b: fetch with gnt and rvalid in the same cycle
    instr_req_i = 1; instr_addr_i = 32'h504;
    tick(); mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h0BADCAFE; #1;
    chk("t6b_gnt", 32'(instr_gnt_o), 1);
    chk("t6b_rvalid", 32'(instr_rvalid_o), 1);
    chk("t6b_rdata", instr_rdata_o, 32'h0BADCAFE);
    chk("t6b_err", 32'(instr_err_o), 0);
    chk("t6b_addr", mem_addr_o, 32'h504);
    tick(); instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; #1;
    chk("t6b_back_idle", 32'({instr_rvalid_o, mem_req_o}), 0);
    tick(); mem_rvalid_i = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
